// File: rtl/bira_pkg.sv
// Shared definitions for the BIRA spare-allocation slice.
//   - Packed entry widths and field offsets for pivot / non-pivot fault entries.
//     Pivot entry:     {en, row[9:0], col[9:0], bnk[1:0], must[2:0]}
//     Non-pivot entry: {en, ptr[2:0], dscrpt, addr[9:0], bnk[1:0]}
//   - Must-repair flag encodings.
//   - Search FSM state type.
package bira_pkg;

    localparam int unsigned PIV_W     = 26;
    localparam int unsigned NPIV_W    = 17;

    // Pivot field LSB offsets
    localparam int unsigned PIV_MUST  = 0;
    localparam int unsigned PIV_BNK   = 3;
    localparam int unsigned PIV_COL   = 5;
    localparam int unsigned PIV_ROW   = 15;
    localparam int unsigned PIV_EN    = 25;

    // Non-pivot field LSB offsets
    localparam int unsigned NP_BNK    = 0;
    localparam int unsigned NP_ADDR   = 2;
    localparam int unsigned NP_DSCRPT = 12;
    localparam int unsigned NP_PTR    = 13;
    localparam int unsigned NP_EN     = 16;

    // Must flags: ROW and ADJ force a spare row, COL forces a spare column
    localparam logic [2:0] MUST_ROW = 3'b100;
    localparam logic [2:0] MUST_COL = 3'b010;
    localparam logic [2:0] MUST_ADJ = 3'b001;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSnap   = 2'd1,
        StSearch = 2'd2,
        StDone   = 2'd3
    } state_e;

endpackage

// File: rtl/spare_cand_eval.sv
// Combinational evaluation of one repair candidate against the fault snapshot.
// Ports:
//   cand   - candidate assignment, bit i = 1: pivot i takes a spare row, 0: a spare column
//   piv    - packed pivot entries (PCAM x PIV_W)
//   npiv   - packed non-pivot entries (NPCAM x NPIV_W)
//   valid  - candidate honours enables, must flags and the spare budgets
//   rows   - spare rows the candidate consumes
//   cols   - spare columns the candidate consumes
module spare_cand_eval
    import bira_pkg::*;
#(
    parameter int unsigned PCAM  = 8,
    parameter int unsigned NPCAM = 30,
    parameter int unsigned SPR   = 2,
    parameter int unsigned SPC   = 2
) (
    input  logic [PCAM-1:0]         cand,
    input  logic [PCAM*PIV_W-1:0]   piv,
    input  logic [NPCAM*NPIV_W-1:0] npiv,
    output logic                    valid,
    output logic [5:0]              rows,
    output logic [5:0]              cols
);

    // Address fields are carried in the snapshot for the fuse stage but play no part in cost
    logic unused_fields;

    always_comb begin : eval
        logic       en;
        logic [2:0] must;
        logic [2:0] ptr;
        logic       dscrpt;
        logic       piv_row;

        valid   = 1'b1;
        rows    = '0;
        cols    = '0;
        en      = 1'b0;
        must    = '0;
        ptr     = '0;
        dscrpt  = 1'b0;
        piv_row = 1'b0;

        for (int i = 0; i < int'(PCAM); i++) begin
            en   = piv[i*PIV_W + PIV_EN];
            must = piv[i*PIV_W + PIV_MUST +: 3];
            if (en) begin
                if (cand[i]) rows = rows + 6'd1;
                else         cols = cols + 6'd1;
                if (((must & (MUST_ROW | MUST_ADJ)) != 3'b000) && !cand[i]) valid = 1'b0;
                if (((must & MUST_COL) != 3'b000) && cand[i])              valid = 1'b0;
            end else if (cand[i]) begin
                valid = 1'b0;
            end
        end

        for (int j = 0; j < int'(NPCAM); j++) begin
            en      = npiv[j*NPIV_W + NP_EN];
            ptr     = npiv[j*NPIV_W + NP_PTR +: 3];
            dscrpt  = npiv[j*NPIV_W + NP_DSCRPT];
            piv_row = 1'b0;
            for (int k = 0; k < int'(PCAM); k++) begin
                if (int'(ptr) == k) piv_row = cand[k];
            end
            if (en) begin
                if (dscrpt && !piv_row) rows = rows + 6'd1;
                if (!dscrpt && piv_row) cols = cols + 6'd1;
            end
        end

        if (rows > 6'(SPR)) valid = 1'b0;
        if (cols > 6'(SPC)) valid = 1'b0;
    end

    always_comb begin
        unused_fields = 1'b0;
        for (int i = 0; i < int'(PCAM); i++) begin
            unused_fields = unused_fields ^ (^piv[i*PIV_W + PIV_ROW +: 10])
                                          ^ (^piv[i*PIV_W + PIV_COL +: 10])
                                          ^ (^piv[i*PIV_W + PIV_BNK +: 2]);
        end
        for (int j = 0; j < int'(NPCAM); j++) begin
            unused_fields = unused_fields ^ (^npiv[j*NPIV_W + NP_ADDR +: 10])
                                          ^ (^npiv[j*NPIV_W + NP_BNK +: 2]);
        end
    end

endmodule

// File: rtl/spare_alloc_search.sv
// Spare row/column allocation search. Snapshots the packed fault entries on start,
// runs cheap fatal pre-checks, then steps one candidate assignment per clock.
// Build option: SPARE_ALLOC_MIN_EN - exhaustive search keeping the cheapest valid
// candidate (ties to lowest cand); when undefined, first-fit with early exit.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   start                - one-cycle request, honoured only when idle
//   pivot_fault_addr     - PCAM packed pivot entries
//   nonpivot_fault_addr  - NPCAM packed non-pivot entries
//   busy                 - snapshot or search in progress
//   done                 - one-cycle pulse, result valid
//   repairable           - result flag
//   solution             - per-pivot row(1)/column(0) choice, zero if unrepairable
//   rows_used, cols_used - spares consumed by the solution
module spare_alloc_search
    import bira_pkg::*;
#(
    parameter int unsigned PCAM  = 8,
    parameter int unsigned NPCAM = 30,
    parameter int unsigned SPR   = 2,
    parameter int unsigned SPC   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [PCAM*PIV_W-1:0]   pivot_fault_addr,
    input  logic [NPCAM*NPIV_W-1:0] nonpivot_fault_addr,
    output logic                    busy,
    output logic                    done,
    output logic                    repairable,
    output logic [PCAM-1:0]         solution,
    output logic [5:0]              rows_used,
    output logic [5:0]              cols_used
);

    state_e                  state_q, state_d;
    logic [PCAM-1:0]         cand_q;
    logic [PCAM*PIV_W-1:0]   piv_q;
    logic [NPCAM*NPIV_W-1:0] npiv_q;

    logic       cand_valid;
    logic [5:0] cand_rows;
    logic [5:0] cand_cols;
    logic       fatal;
    logic       last_cand;

    spare_cand_eval #(
        .PCAM  (PCAM),
        .NPCAM (NPCAM),
        .SPR   (SPR),
        .SPC   (SPC)
    ) u_eval (
        .cand  (cand_q),
        .piv   (piv_q),
        .npiv  (npiv_q),
        .valid (cand_valid),
        .rows  (cand_rows),
        .cols  (cand_cols)
    );

    assign last_cand = &cand_q;
    assign busy      = (state_q == StSnap) || (state_q == StSearch);
    assign done      = (state_q == StDone);

    // Pre-checks look at the live inputs during SNAP, the same values being captured
    always_comb begin : precheck
        logic [5:0] n_en;
        logic [2:0] must;
        n_en  = '0;
        must  = '0;
        fatal = 1'b0;
        for (int i = 0; i < int'(PCAM); i++) begin
            must = pivot_fault_addr[i*PIV_W + PIV_MUST +: 3];
            if (pivot_fault_addr[i*PIV_W + PIV_EN]) begin
                n_en = n_en + 6'd1;
                if (((must & (MUST_ROW | MUST_ADJ)) != 3'b000) &&
                    ((must & MUST_COL) != 3'b000)) begin
                    fatal = 1'b1;
                end
            end
        end
        if (n_en > 6'(SPR + SPC)) fatal = 1'b1;
    end

`ifdef SPARE_ALLOC_MIN_EN
    logic            found_q;
    logic [PCAM-1:0] best_sol_q;
    logic [5:0]      best_rows_q;
    logic [5:0]      best_cols_q;
    logic            take;

    // Strict less-than keeps the earliest (lowest cand) of equal-cost candidates
    assign take = cand_valid &&
                  (!found_q || (({1'b0, cand_rows} + {1'b0, cand_cols}) <
                                ({1'b0, best_rows_q} + {1'b0, best_cols_q})));
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StSnap;
            StSnap:   state_d = fatal ? StDone : StSearch;
`ifdef SPARE_ALLOC_MIN_EN
            StSearch: if (last_cand) state_d = StDone;
`else
            StSearch: if (cand_valid || last_cand) state_d = StDone;
`endif
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cand_q      <= '0;
            piv_q       <= '0;
            npiv_q      <= '0;
            repairable  <= 1'b0;
            solution    <= '0;
            rows_used   <= '0;
            cols_used   <= '0;
`ifdef SPARE_ALLOC_MIN_EN
            found_q     <= 1'b0;
            best_sol_q  <= '0;
            best_rows_q <= '0;
            best_cols_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                StSnap: begin
                    piv_q       <= pivot_fault_addr;
                    npiv_q      <= nonpivot_fault_addr;
                    cand_q      <= '0;
                    repairable  <= 1'b0;
                    solution    <= '0;
                    rows_used   <= '0;
                    cols_used   <= '0;
`ifdef SPARE_ALLOC_MIN_EN
                    found_q     <= 1'b0;
                    best_sol_q  <= '0;
                    best_rows_q <= '0;
                    best_cols_q <= '0;
`endif
                end
                StSearch: begin
                    cand_q <= cand_q + PCAM'(1);
`ifdef SPARE_ALLOC_MIN_EN
                    if (take) begin
                        found_q     <= 1'b1;
                        best_sol_q  <= cand_q;
                        best_rows_q <= cand_rows;
                        best_cols_q <= cand_cols;
                    end
                    if (last_cand) begin
                        if (take) begin
                            repairable <= 1'b1;
                            solution   <= cand_q;
                            rows_used  <= cand_rows;
                            cols_used  <= cand_cols;
                        end else if (found_q) begin
                            repairable <= 1'b1;
                            solution   <= best_sol_q;
                            rows_used  <= best_rows_q;
                            cols_used  <= best_cols_q;
                        end else begin
                            repairable <= 1'b0;
                            solution   <= '0;
                            rows_used  <= '0;
                            cols_used  <= '0;
                        end
                    end
`else
                    if (cand_valid) begin
                        repairable <= 1'b1;
                        solution   <= cand_q;
                        rows_used  <= cand_rows;
                        cols_used  <= cand_cols;
                    end else if (last_cand) begin
                        repairable <= 1'b0;
                        solution   <= '0;
                        rows_used  <= '0;
                        cols_used  <= '0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spare_alloc_search.sv
module tb_spare_alloc_search;

    localparam int PCAM  = 8;
    localparam int NPCAM = 30;
    localparam int PW    = 26;
    localparam int NW    = 17;
`ifdef SPARE_ALLOC_MIN_EN
    localparam bit MIN_MODE = 1'b1;
`else
    localparam bit MIN_MODE = 1'b0;
`endif
    localparam int FULL = (1 << PCAM) + 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [PCAM*PW-1:0]   pv_in;
    logic [NPCAM*NW-1:0]  nv_in;
    logic                 busy, done, repairable;
    logic [PCAM-1:0]      solution;
    logic [5:0]           rows_used, cols_used;

    spare_alloc_search dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .pivot_fault_addr    (pv_in),
        .nonpivot_fault_addr (nv_in),
        .busy                (busy),
        .done                (done),
        .repairable          (repairable),
        .solution            (solution),
        .rows_used           (rows_used),
        .cols_used           (cols_used)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Configuration under construction and expected outcome
    logic [PCAM*PW-1:0]  pv_t;
    logic [NPCAM*NW-1:0] nv_t;
    bit                  exp_rep;
    logic [7:0]          exp_sol;
    int                  exp_rows, exp_cols, exp_lat;
    bit                  armed = 1'b0;
    int                  cyc = 0;

    task automatic clear_cfg();
        pv_t = '0;
        nv_t = '0;
    endtask

    task automatic set_piv(input int i, input logic [2:0] must);
        logic [9:0] r;
        logic [9:0] c;
        r = 10'(i * 37 + 3);
        c = 10'(i * 11 + 5);
        pv_t[i*PW +: PW] = {1'b1, r, c, 2'(i), must};
    endtask

    task automatic set_np(input int j, input logic [2:0] ptr, input bit shares_col);
        np_slot: begin
            logic [9:0] a;
            a = 10'(j * 13 + 1);
            nv_t[j*NW +: NW] = {1'b1, ptr, shares_col, a, 2'(j)};
        end
    endtask

    // Reference: enumerate every assignment, count spares from the fault lists directly
    task automatic model(output bit rep, output logic [7:0] sol, output int nr, output int nc,
                         output int lat);
        int  n_en;
        bit  fatal;
        int  best;
        n_en  = 0;
        fatal = 1'b0;
        rep = 1'b0; sol = '0; nr = 0; nc = 0; lat = FULL;
        for (int i = 0; i < PCAM; i++) begin
            logic [2:0] m;
            m = pv_t[i*PW +: 3];
            if (pv_t[i*PW + 25]) begin
                n_en++;
                if ((m[2] || m[0]) && m[1]) fatal = 1'b1;
            end
        end
        if (n_en > 4) fatal = 1'b1;
        if (fatal) begin
            lat = 2;
            return;
        end
        best = 1000;
        for (int c = 0; c < (1 << PCAM); c++) begin
            bit ok;
            int r, k;
            ok = 1'b1; r = 0; k = 0;
            for (int i = 0; i < PCAM; i++) begin
                bit        as_row;
                logic [2:0] m;
                as_row = ((c >> i) & 1) == 1;
                m      = pv_t[i*PW +: 3];
                if (!pv_t[i*PW + 25]) begin
                    if (as_row) ok = 1'b0;
                end else begin
                    if (as_row) r++; else k++;
                    if ((m[2] || m[0]) && !as_row) ok = 1'b0;
                    if (m[1] && as_row) ok = 1'b0;
                end
            end
            for (int j = 0; j < NPCAM; j++) begin
                int p;
                bit prow;
                p    = int'(nv_t[j*NW + 13 +: 3]);
                prow = ((c >> p) & 1) == 1;
                if (nv_t[j*NW + 16]) begin
                    if (nv_t[j*NW + 12] && !prow) r++;
                    if (!nv_t[j*NW + 12] && prow) k++;
                end
            end
            if (r > 2 || k > 2) ok = 1'b0;
            if (ok) begin
                if (!MIN_MODE) begin
                    rep = 1'b1; sol = 8'(c); nr = r; nc = k; lat = 3 + c;
                    return;
                end else if (r + k < best) begin
                    best = r + k;
                    rep = 1'b1; sol = 8'(c); nr = r; nc = k;
                end
            end
        end
    endtask

    // Per-cycle compare against the expected timeline of the armed transaction
    always @(negedge clk) begin
        if (armed) begin
            cyc = cyc + 1;
            checks++;
            if (done !== (cyc == exp_lat)) begin
                errors++;
                $display("FAIL done cyc=%0d got=%b want=%b", cyc, done, cyc == exp_lat);
            end
            checks++;
            if (busy !== (cyc < exp_lat)) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, cyc < exp_lat);
            end
            if (cyc >= exp_lat) begin
                checks++;
                if (repairable !== exp_rep || solution !== exp_sol ||
                    rows_used !== 6'(exp_rows) || cols_used !== 6'(exp_cols)) begin
                    errors++;
                    $display("FAIL result got rep=%b sol=%h r=%0d c=%0d want rep=%b sol=%h r=%0d c=%0d",
                             repairable, solution, rows_used, cols_used,
                             exp_rep, exp_sol, exp_rows, exp_cols);
                end
                armed = 1'b0;
            end
        end else if (!rst) begin
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL stray_done got=%b want=0", done);
            end
        end
    end

    task automatic run_case(input string name, input bit disturb, input bit l_rep,
                            input logic [7:0] l_sol, input int l_rows, input int l_cols,
                            input int l_lat);
        model(exp_rep, exp_sol, exp_rows, exp_cols, exp_lat);
        checks++;
        if (exp_rep !== l_rep || exp_sol !== l_sol || exp_rows != l_rows ||
            exp_cols != l_cols || exp_lat != l_lat) begin
            errors++;
            $display("FAIL model_%s got rep=%b sol=%h r=%0d c=%0d lat=%0d want rep=%b sol=%h r=%0d c=%0d lat=%0d",
                     name, exp_rep, exp_sol, exp_rows, exp_cols, exp_lat,
                     l_rep, l_sol, l_rows, l_cols, l_lat);
        end
        pv_in = pv_t;
        nv_in = nv_t;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc   = 0;
        armed = 1'b1;
        if (disturb) begin
            // Restart request and input churn mid-search must both be ignored
            repeat (4) @(negedge clk);
            start = 1'b1;
            pv_in = ~pv_t;
            nv_in = ~nv_t;
            @(posedge clk);
            #1 start = 1'b0;
        end
        for (int t = 0; t < FULL + 40 && armed; t++) @(negedge clk);
        #1;
        if (armed) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s got=no_done want=done_at_%0d", name, exp_lat);
            armed = 1'b0;
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (repairable !== exp_rep || solution !== exp_sol ||
            rows_used !== 6'(exp_rows) || cols_used !== 6'(exp_cols)) begin
            errors++;
            $display("FAIL hold_%s got rep=%b sol=%h r=%0d c=%0d want rep=%b sol=%h r=%0d c=%0d",
                     name, repairable, solution, rows_used, cols_used,
                     exp_rep, exp_sol, exp_rows, exp_cols);
        end
    endtask

    task automatic check_idle_zero(input string name);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || repairable !== 1'b0 || solution !== 8'h00 ||
            rows_used !== 6'd0 || cols_used !== 6'd0) begin
            errors++;
            $display("FAIL %s got busy=%b done=%b rep=%b sol=%h r=%0d c=%0d want all zero",
                     name, busy, done, repairable, solution, rows_used, cols_used);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        pv_in = '0;
        nv_in = '0;
        repeat (3) @(posedge clk);
        #1 check_idle_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Two free pivots
        clear_cfg(); set_piv(0, 3'b000); set_piv(1, 3'b000);
        run_case("two_free", 0, 1, 8'h00, 0, 2, MIN_MODE ? FULL : 3);

        // Forced row on pivot 0, forced column on pivot 1
        clear_cfg(); set_piv(0, 3'b100); set_piv(1, 3'b010);
        run_case("must_mix", 0, 1, 8'h01, 1, 1, MIN_MODE ? FULL : 4);

        // Five pivots exceed four spares
        clear_cfg();
        for (int i = 0; i < 5; i++) set_piv(i, 3'b000);
        run_case("too_many", 0, 0, 8'h00, 0, 0, 2);

        // Row-sharing non-pivots cost columns only when the pivot takes a row
        clear_cfg(); set_piv(0, 3'b000);
        for (int j = 0; j < 3; j++) set_np(j, 3'd0, 1'b0);
        run_case("np_row3", 0, 1, 8'h00, 0, 1, MIN_MODE ? FULL : 3);

        // Contradictory must flags
        clear_cfg(); set_piv(0, 3'b110);
        run_case("must_conflict", 0, 0, 8'h00, 0, 0, 2);

        // Column-sharing non-pivot
        clear_cfg(); set_piv(0, 3'b000); set_np(0, 3'd0, 1'b1);
        if (MIN_MODE) run_case("np_col1", 0, 1, 8'h01, 1, 0, FULL);
        else          run_case("np_col1", 0, 1, 8'h00, 1, 1, 3);

        // Three pivots, two column-sharing non-pivots
        clear_cfg();
        for (int i = 0; i < 3; i++) set_piv(i, 3'b000);
        set_np(0, 3'd0, 1'b1); set_np(1, 3'd1, 1'b1);
        if (MIN_MODE) run_case("three_piv", 0, 1, 8'h03, 2, 1, FULL);
        else          run_case("three_piv", 0, 1, 8'h01, 2, 2, 4);

        // No enabled pivots at all
        clear_cfg();
        run_case("empty", 0, 1, 8'h00, 0, 0, MIN_MODE ? FULL : 3);

        // Exhaustive unrepairable search with start and input churn during the run
        clear_cfg(); set_piv(0, 3'b000);
        for (int j = 0; j < 3; j++) set_np(j, 3'd0, 1'b1);
        for (int j = 3; j < 6; j++) set_np(j, 3'd0, 1'b0);
        run_case("unrepairable", 1, 0, 8'h00, 0, 0, FULL);

        // Reset during SEARCH aborts with no done pulse
        pv_in = pv_t;
        nv_in = nv_t;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_before_rst got=%b want=1", busy);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_idle_zero("abort_rst");
        repeat (FULL + 10) @(negedge clk);
        #1 check_idle_zero("after_abort");

        // Normal operation resumes after the abort
        clear_cfg(); set_piv(0, 3'b100); set_piv(1, 3'b010);
        run_case("post_rst", 0, 1, 8'h01, 1, 1, MIN_MODE ? FULL : 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
